// File: rtl/lc3b_ctrl_pipe.sv
// LC-3b control pipeline: decodes instructions into packed control words and carries
// them through STAGES registers with load-use bubble insertion, global stall and partial flush.
module lc3b_ctrl_pipe #(
  parameter int STAGES      = 3,
  parameter int CTRL_W      = 24,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid_in,
  input  logic [15:0]              id_instr,
  input  logic                     stall_in,
  input  logic                     flush_in,
  output logic                     id_ready,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [CNT_W-1:0]         hazard_count
);

  localparam logic [3:0] OP_BR  = 4'd0,  OP_ADD = 4'd1,  OP_LDB = 4'd2,  OP_STB = 4'd3;
  localparam logic [3:0] OP_JSR = 4'd4,  OP_AND = 4'd5,  OP_LDR = 4'd6,  OP_STR = 4'd7;
  localparam logic [3:0] OP_RTI = 4'd8,  OP_NOT = 4'd9,  OP_LDI = 4'd10, OP_STI = 4'd11;
  localparam logic [3:0] OP_JMP = 4'd12, OP_SHF = 4'd13, OP_LEA = 4'd14, OP_TRAP = 4'd15;

  function automatic logic [23:0] decodeInstr(input logic [15:0] ir);
    logic       ldRf, ldCc, memRd, memWr, sr1Used, sr2Used;
    logic [1:0] byteEn;
    logic [2:0] aluOp, dest, sr1, sr2;
    ldRf = 1'b0; ldCc = 1'b0; memRd = 1'b0; memWr = 1'b0;
    sr1Used = 1'b0; sr2Used = 1'b0; byteEn = 2'b00;
    aluOp = 3'd0; dest = 3'd0; sr1 = 3'd0; sr2 = 3'd0;
    case (ir[15:12])
      OP_ADD, OP_AND: begin
        ldRf = 1'b1; ldCc = 1'b1;
        aluOp = (ir[15:12] == OP_AND) ? 3'd1 : 3'd0;
        dest = ir[11:9]; sr1 = ir[8:6]; sr1Used = 1'b1;
        if (!ir[5]) begin
          sr2 = ir[2:0]; sr2Used = 1'b1;
        end
      end
      OP_NOT: begin
        ldRf = 1'b1; ldCc = 1'b1; aluOp = 3'd2;
        dest = ir[11:9]; sr1 = ir[8:6]; sr1Used = 1'b1;
      end
      OP_SHF: begin
        ldRf = 1'b1; ldCc = 1'b1;
        dest = ir[11:9]; sr1 = ir[8:6]; sr1Used = 1'b1;
        aluOp = !ir[4] ? 3'd4 : (!ir[5] ? 3'd5 : 3'd6);
      end
      OP_LDR, OP_LDI, OP_LDB: begin
        ldRf = 1'b1; ldCc = 1'b1; memRd = 1'b1;
        byteEn = (ir[15:12] == OP_LDB) ? 2'b01 : 2'b11;
        dest = ir[11:9]; sr1 = ir[8:6]; sr1Used = 1'b1;
      end
      OP_STR, OP_STI, OP_STB: begin
        memWr = 1'b1;
        byteEn = (ir[15:12] == OP_STB) ? 2'b01 : 2'b11;
        sr1 = ir[8:6]; sr1Used = 1'b1; sr2 = ir[11:9]; sr2Used = 1'b1;
      end
      OP_LEA: begin
        ldRf = 1'b1; ldCc = 1'b1; aluOp = 3'd3; dest = ir[11:9];
      end
      OP_JSR: begin
        ldRf = 1'b1; dest = 3'd7;
        if (!ir[11]) begin
          sr1 = ir[8:6]; sr1Used = 1'b1;
        end
      end
      OP_JMP: begin
        sr1 = ir[8:6]; sr1Used = 1'b1;
      end
      OP_TRAP: begin
        ldRf = 1'b1; memRd = 1'b1; byteEn = 2'b11; dest = 3'd7;
      end
      default: ;
    endcase
    return {sr1Used, sr2Used, sr2, sr1, dest, aluOp, byteEn, memWr, memRd, ldCc, ldRf, ir[15:12]};
  endfunction

  logic [STAGES-1:0]             stageValid_q, stageValid_d;
  logic [STAGES-1:0][CTRL_W-1:0] stageCtrl_q, stageCtrl_d;
  logic [CNT_W-1:0]              hazardCnt_q, hazardCnt_d;
  logic [23:0]                   idDecoded;
  logic [2:0]                    exDest;
  logic                          hazard;

  assign idDecoded = decodeInstr(id_instr);
  assign exDest    = stageCtrl_q[0][15:13];

  // A load in EX cannot forward its result to a consumer decoding right now.
  assign hazard = stageValid_q[0] && stageCtrl_q[0][6] && stageCtrl_q[0][4] && id_valid_in &&
                  ((idDecoded[23] && (idDecoded[18:16] == exDest)) ||
                   (idDecoded[22] && (idDecoded[21:19] == exDest)));

  assign id_ready     = !reset && !stall_in && !flush_in && !hazard;
  assign stage_valid  = stageValid_q;
  assign stage_ctrl   = stageCtrl_q;
  assign hazard_count = hazardCnt_q;

  always_comb begin
    stageValid_d = stageValid_q;
    stageCtrl_d  = stageCtrl_q;
    hazardCnt_d  = hazardCnt_q;
    if (flush_in) begin
      if (!stall_in) begin
        for (int i = 1; i < STAGES; i++) begin
          stageValid_d[i] = stageValid_q[i-1];
          stageCtrl_d[i]  = stageCtrl_q[i-1];
        end
      end
      // Flushed stages keep stale ctrl; only the valid bit is authoritative.
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        stageValid_d[i] = 1'b0;
      end
    end else if (!stall_in) begin
      for (int i = 1; i < STAGES; i++) begin
        stageValid_d[i] = stageValid_q[i-1];
        stageCtrl_d[i]  = stageCtrl_q[i-1];
      end
      stageValid_d[0] = id_ready && id_valid_in;
      stageCtrl_d[0]  = (id_ready && id_valid_in) ? CTRL_W'(idDecoded) : '0;
      if (hazard && (hazardCnt_q != '1)) begin
        hazardCnt_d = hazardCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stageValid_q <= '0;
      stageCtrl_q  <= '0;
      hazardCnt_q  <= '0;
    end else begin
      stageValid_q <= stageValid_d;
      stageCtrl_q  <= stageCtrl_d;
      hazardCnt_q  <= hazardCnt_d;
    end
  end

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// Bench for lc3b_ctrl_pipe: directed scenarios then random traffic, all checked against
// a field-level decode model and an array-based pipeline model.
module tb_lc3b_ctrl_pipe;
  localparam int STAGES = 3;
  localparam int CW     = 24;
  localparam int FD     = 1;
  localparam int CNTW   = 4;

  logic                 clk = 1'b0;
  logic                 reset, idValid, stall, flush;
  logic [15:0]          instr;
  logic                 idReady;
  logic [STAGES-1:0]    stageValid;
  logic [STAGES*CW-1:0] stageCtrl;
  logic [CNTW-1:0]      hazardCount;

  int compares = 0;
  int mismatches = 0;

  // model state
  logic [STAGES-1:0] mv;
  logic [CW-1:0]     mc [STAGES];
  logic [STAGES-1:0] mk;
  int                mcnt;
  logic              readyObs;

  lc3b_ctrl_pipe #(.STAGES(STAGES), .CTRL_W(CW), .FLUSH_DEPTH(FD), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset), .id_valid_in(idValid), .id_instr(instr),
    .stall_in(stall), .flush_in(flush), .id_ready(idReady),
    .stage_valid(stageValid), .stage_ctrl(stageCtrl), .hazard_count(hazardCount)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] refDecode(input logic [15:0] ir);
    int op, ldRf, ldCc, memRd, memWr, be, alu, dest, sr1, sr2, u1, u2;
    bit isAlu, isNot, isShf, isLd, isSt, isLea, isJsr, isJmp, isTrap;
    op = int'(ir[15:12]);
    isAlu = (op == 1) || (op == 5);
    isNot = (op == 9);  isShf = (op == 13); isLea = (op == 14);
    isLd  = (op == 2) || (op == 6) || (op == 10);
    isSt  = (op == 3) || (op == 7) || (op == 11);
    isJsr = (op == 4);  isJmp = (op == 12); isTrap = (op == 15);
    ldRf  = (isAlu || isNot || isShf || isLd || isLea || isJsr || isTrap) ? 1 : 0;
    ldCc  = (isAlu || isNot || isShf || isLd || isLea) ? 1 : 0;
    memRd = (isLd || isTrap) ? 1 : 0;
    memWr = isSt ? 1 : 0;
    be    = (isLd || isSt) ? ((op == 2 || op == 3) ? 1 : 3) : (isTrap ? 3 : 0);
    alu   = (op == 5) ? 1 : isNot ? 2 : isLea ? 3 :
            isShf ? (!ir[4] ? 4 : (!ir[5] ? 5 : 6)) : 0;
    dest  = (isAlu || isNot || isShf || isLd || isLea) ? int'(ir[11:9]) :
            (isJsr || isTrap) ? 7 : 0;
    u1    = (isAlu || isNot || isShf || isLd || isSt || isJmp || (isJsr && !ir[11])) ? 1 : 0;
    sr1   = u1 ? int'(ir[8:6]) : 0;
    u2    = ((isAlu && !ir[5]) || isSt) ? 1 : 0;
    sr2   = (isAlu && !ir[5]) ? int'(ir[2:0]) : isSt ? int'(ir[11:9]) : 0;
    return CW'(op + ldRf * 16 + ldCc * 32 + memRd * 64 + memWr * 128 + be * 256 +
               alu * 1024 + dest * 8192 + sr1 * 65536 + sr2 * 524288 +
               u2 * 4194304 + u1 * 8388608);
  endfunction

  function automatic bit refHazard(input logic v, input logic [15:0] ir);
    logic [CW-1:0] d;
    int exDest;
    d = refDecode(ir);
    exDest = int'(mc[0][15:13]);
    return mv[0] && mc[0][6] && mc[0][4] && v &&
           ((d[23] && int'(d[18:16]) == exDest) || (d[22] && int'(d[21:19]) == exDest));
  endfunction

  task automatic checkOutput();
    compares++;
    assert (stageValid === mv) else begin
      mismatches++;
      $error("[TB] FAIL stage_valid got %b expected %b", stageValid, mv);
    end
    for (int i = 0; i < STAGES; i++) begin
      if (mk[i]) begin
        compares++;
        assert (stageCtrl[i*CW +: CW] === mc[i]) else begin
          mismatches++;
          $error("[TB] FAIL stage_ctrl[%0d] got %h expected %h", i, stageCtrl[i*CW +: CW], mc[i]);
        end
      end
    end
    compares++;
    assert (hazardCount === CNTW'(mcnt)) else begin
      mismatches++;
      $error("[TB] FAIL hazard_count got %0d expected %0d", hazardCount, mcnt);
    end
  endtask

  // One clock: drive, check id_ready, step the model on the edge, check registered outputs.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] ir,
                               input logic st, input logic fl);
    bit hz, rdy;
    @(negedge clk);
    reset = r; idValid = v; instr = ir; stall = st; flush = fl;
    #1;
    hz  = refHazard(v, ir);
    rdy = !r && !st && !fl && !hz;
    readyObs = idReady;
    compares++;
    assert (idReady === rdy) else begin
      mismatches++;
      $error("[TB] FAIL id_ready got %b expected %b", idReady, rdy);
    end
    @(posedge clk);
    if (r) begin
      mv = '0; mk = '1; mcnt = 0;
      for (int i = 0; i < STAGES; i++) mc[i] = '0;
    end else if (fl) begin
      if (!st) begin
        for (int i = STAGES - 1; i >= 1; i--) begin
          mv[i] = mv[i-1]; mc[i] = mc[i-1]; mk[i] = mk[i-1];
        end
      end
      for (int i = 0; i < FD; i++) begin
        mv[i] = 1'b0; mk[i] = 1'b0;
      end
    end else if (!st) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        mv[i] = mv[i-1]; mc[i] = mc[i-1]; mk[i] = mk[i-1];
      end
      mv[0] = rdy && v;
      mc[0] = (rdy && v) ? refDecode(ir) : '0;
      mk[0] = 1'b1;
      if (hz && mcnt < (1 << CNTW) - 1) mcnt++;
    end
    #1;
    checkOutput();
  endtask

  task automatic expectConst(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    assert (got === exp) else begin
      mismatches++;
      $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    mv = '0; mk = '0; mcnt = 0; readyObs = 1'b0;
    for (int i = 0; i < STAGES; i++) mc[i] = '0;
    reset = 1'b1; idValid = 1'b0; instr = '0; stall = 1'b0; flush = 1'b0;

    // Reset for two cycles.
    applyStimulus(1, 0, 16'h0, 0, 0);
    expectConst("reset_ready", 32'(readyObs), 32'd0);
    applyStimulus(1, 0, 16'h0, 0, 0);
    expectConst("reset_valid", 32'(stageValid), 32'd0);
    expectConst("reset_count", 32'(hazardCount), 32'd0);

    // ADD R1,R2,R3 flows to stage 2 after three edges.
    applyStimulus(0, 1, 16'h1283, 0, 0);
    expectConst("add_stage0", 32'(stageCtrl[0 +: CW]), 32'hDA2031);
    applyStimulus(0, 0, 16'h0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0);
    expectConst("add_stage2_valid", 32'(stageValid), 32'b100);
    expectConst("add_stage2", 32'(stageCtrl[2*CW +: CW]), 32'hDA2031);

    // Load-use: LDR R4,R5,#0 then ADD R6,R4,R4.
    applyStimulus(0, 1, 16'h6940, 0, 0);
    applyStimulus(0, 1, 16'h1D04, 0, 0);
    expectConst("hz_ready", 32'(readyObs), 32'd0);
    expectConst("hz_bubble", 32'(stageCtrl[0 +: CW]), 32'd0);
    expectConst("hz_count", 32'(hazardCount), 32'd1);
    applyStimulus(0, 1, 16'h1D04, 0, 0);
    expectConst("hz_enter", 32'(stageValid[0]), 32'd1);

    // Fill all stages, then stall three cycles.
    applyStimulus(0, 1, 16'h5A42, 0, 0);
    applyStimulus(0, 1, 16'h987F, 0, 0);
    applyStimulus(0, 1, 16'hE3FF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 16'h1283, 1, 0);
      expectConst("stall_ready", 32'(readyObs), 32'd0);
      expectConst("stall_valid", 32'(stageValid), 32'b111);
    end

    // Flush with a full pipe.
    applyStimulus(0, 1, 16'h1283, 0, 1);
    expectConst("flush_valid", 32'(stageValid), 32'b110);

    // Drive hazard_count into saturation and past it.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 16'h2000 | 16'(i % 8) << 9, 0, 0);
      applyStimulus(0, 1, 16'h7000 | 16'(i % 8) << 6, 0, 0);
      applyStimulus(0, 0, 16'h0, 0, 0);
    end
    expectConst("count_sat", 32'(hazardCount), 32'hF);

    // Random traffic, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ir;
      logic r, v, st, fl;
      ir = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ir[15:12] = 4'd6;
      if ($urandom_range(0, 2) == 0) ir[8:6] = mc[0][15:13];
      r  = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 99) < 15);
      fl = ($urandom_range(0, 99) < 10);
      applyStimulus(r, v, ir, st, fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
